l15_mem_responder: RTL



---
 rtl/l15_mem_responder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/l15_mem_responder.sv
// In-order memory responder for the L1.5-style big-endian memory port.
// Requests are queued in a FIFO, serviced from a word-addressed SRAM and answered after a fixed latency.
module l15_mem_responder #(
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned MemTidWidth = 2,
    parameter int unsigned LineWidth   = 128,
    parameter int unsigned MemWords    = 1024,
    parameter int unsigned Latency     = 2,
    parameter int unsigned FifoDepth   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_val_i,
    output logic                   req_rdy_o,
    input  logic [1:0]             req_type_i,
    input  logic [MemTidWidth-1:0] req_tid_i,
    input  logic [AddrWidth-1:0]   req_addr_i,
    input  logic [1:0]             req_size_i,
    input  logic [63:0]            req_data_i,
    output logic                   rtrn_val_o,
    input  logic                   rtrn_rdy_i,
    output logic [1:0]             rtrn_type_o,
    output logic [MemTidWidth-1:0] rtrn_tid_o,
    output logic [LineWidth-1:0]   rtrn_data_o
);

    localparam int unsigned IdxW      = $clog2(MemWords);
    localparam int unsigned LineWords = LineWidth / 64;
    localparam int unsigned PtrW      = $clog2(FifoDepth);
    localparam int unsigned CntW      = $clog2(Latency + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic [1:0]             typ;
        logic [MemTidWidth-1:0] tid;
        logic [AddrWidth-1:0]   addr;
        logic [1:0]             size;
        logic [63:0]            data;
    } req_t;

    req_t             fifo_mem [FifoDepth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [PtrW:0]    count;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    state_t           state;
    logic [CntW-1:0]  cnt;
    req_t             cur;

    logic [63:0]          mem [MemWords];
    logic [IdxW-1:0]      idx;
    logic [IdxW-1:0]      base_idx;
    logic                 hi_nz;
    logic [2:0]           size_m;
    logic                 misal;
    logic                 err;
    logic [63:0]          wmask;
    logic                 mem_we;
    logic [LineWidth-1:0] line_rd;
    logic [1:0]           resp_type;
    logic [LineWidth-1:0] resp_data;

    assign fifo_empty = (count == '0);
    assign req_rdy_o  = (count != (PtrW+1)'(FifoDepth));
    assign push       = req_val_i && req_rdy_o;
    assign pop        = !fifo_empty && ((state == S_IDLE) || (state == S_RESP && rtrn_rdy_i));

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {req_type_i, req_tid_i, req_addr_i, req_size_i, req_data_i};
        end
    end

    // Address decode and error classification of the request being serviced.
    assign idx       = cur.addr[3 +: IdxW];
    assign base_idx  = idx & ~IdxW'(LineWords - 1);
    assign hi_nz     = |(cur.addr >> (3 + IdxW));
    assign size_m    = 3'((4'd1 << cur.size) - 4'd1);
    assign misal     = (cur.typ == 2'd2) && |(cur.addr[2:0] & size_m);
    assign err       = hi_nz || misal || (cur.typ == 2'd3);
    assign mem_we    = rst_ni && (state == S_WAIT) && (cnt == '0) && (cur.typ == 2'd2) && !err;
    assign resp_type = err ? 2'd3 : cur.typ;
    assign resp_data = (!err && cur.typ != 2'd2) ? line_rd : '0;

    // Big-endian byte enables: byte k of a word lives in bits [63-8k -: 8].
    always_comb begin
        wmask = '0;
        for (int k = 0; k < 8; k++) begin
            if (3'(k) >= cur.addr[2:0] && 4'(k) < ({1'b0, cur.addr[2:0]} + (4'd1 << cur.size))) begin
                wmask[63-8*k -: 8] = 8'hFF;
            end
        end
    end

    always_comb begin
        line_rd = '0;
        for (int i = 0; i < int'(LineWords); i++) begin
            line_rd[LineWidth-1-64*i -: 64] = mem[base_idx | IdxW'(i)];
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[idx] <= (mem[idx] & ~wmask) | (cur.data & wmask);
        end
    end

    // FIFO pointers plus IDLE/WAIT/RESP sequencing with registered response outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            state       <= S_IDLE;
            cnt         <= '0;
            cur         <= '0;
            rtrn_val_o  <= 1'b0;
            rtrn_type_o <= 2'd0;
            rtrn_tid_o  <= '0;
            rtrn_data_o <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            count <= count + (PtrW+1)'(push) - (PtrW+1)'(pop);

            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        rtrn_val_o  <= 1'b1;
                        rtrn_type_o <= resp_type;
                        rtrn_tid_o  <= cur.tid;
                        rtrn_data_o <= resp_data;
                        state       <= S_RESP;
                    end else begin
                        cnt <= cnt - CntW'(1);
                    end
                end
                S_RESP: begin
                    if (rtrn_rdy_i) begin
                        rtrn_val_o <= 1'b0;
                        state      <= fifo_empty ? S_IDLE : S_WAIT;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (pop) begin
                cur <= fifo_mem[rd_ptr];
                cnt <= CntW'(Latency - 1);
            end
        end
    end

endmodule
